rvv_ahb_arbiter: RTL and testbench
==================================

# rvv_ahb_arbiter

Two-master AHB-Lite arbiter that shares the core's single external AHB port between the scalar pipeline (master 0) and the vector unit (master 1). It replaces the plain request/ready-driven mux with a pipelined arbiter. The arbiter tracks address-phase and data-phase ownership separately, so a grant switch never corrupts an in-flight transfer. It sits between the scalar and vector AHB master ports and the top-level `haddr_o`/`hrdata_i` bus.

## Interface
Parameters:
- DATA_WIDTH, 32, address/data width
- RR_EN, 1, 1 = round-robin between masters when unlocked; 0 = fixed priority, vector over scalar

Ports:
- clk_i  in  1  single clock, rising edge
- resetn_i  in  1  reset, asynchronous, active-low
- s_req_i / v_req_i  in  1  master has a valid transfer; address/control held stable until accepted
- s_haddr_i / v_haddr_i  in  DATA_WIDTH  address phase
- s_hwrite_i / v_hwrite_i  in  1  write flag
- s_hsize_i / v_hsize_i  in  3  hsize_t
- s_hwdata_i / v_hwdata_i  in  DATA_WIDTH  write data, data phase
- v_lock_i  in  1  vector exclusive ownership; held high from vreq to vready
- s_gnt_o / v_gnt_o  out  1  master owns the address phase
- s_hready_o / v_hready_o  out  1  per-master ready
- s_hresp_o / v_hresp_o  out  2  per-master response
- hrdata_o  out  DATA_WIDTH  broadcast read data (hrdata_i)
- haddr_o, hwdata_o  out  DATA_WIDTH  bus address/write data
- hsize_o  out  3; hwrite_o  out  1; htrans_o  out  2  bus control
- hrdata_i  in  DATA_WIDTH; hready_i  in  1; hresp_i  in  2  bus slave response

## Operation
- Registers: addr_owner, data_owner, last_owner. Each takes one of {NONE, SCALAR, VECTOR}. Reset value of all three is NONE.
- Accept: `acc = gnt_m & req_m & hready_i`. On acc, data_owner <= addr_owner. If hready_i is high with no acc, data_owner <= NONE. If hready_i is low, data_owner holds.
- Arbitration happens only on cycles where hready_i = 1. The next addr_owner is chosen in this order:
  - v_lock_i = 1 -> VECTOR.
  - Both requests pending:
    - RR_EN = 1 -> the master that is not last_owner.
    - RR_EN = 0 -> VECTOR.
    - The requests counted here are those still pending after this cycle's acc. A master accepted this cycle counts as not requesting unless it re-asserts req.
  - Exactly one request pending -> that master.
  - Otherwise NONE.
- On acc, last_owner <= addr_owner.
- While hready_i = 0, addr_owner and data_owner freeze.
- Lock behaviour:
  - With v_lock_i high, scalar is never granted.
  - If lock rises while SCALAR owns the address phase, ownership moves to VECTOR at the next hready_i = 1 edge.
  - A scalar data phase already in flight completes normally.
- Address mux follows addr_owner:
  - NONE -> haddr_o = 0, hwrite_o = 0, hsize_o = WORD, htrans_o = IDLE (2'b00).
  - Owned -> htrans_o = NONSEQ (2'b10) when req_m is high, IDLE otherwise.
- hwdata_o follows data_owner; it is 0 when data_owner = NONE.
- Per-master responses:
  - `m_hready_o = hready_i & (gnt_m | data_owner==m)`.
  - `m_hresp_o = (data_owner==m) ? hresp_i : OKAY`.
- An ERROR response (hresp_i = 01) is routed only to the data owner. It does not change arbitration.

## Timing
- Grant latency: req rises in cycle N with the bus idle -> gnt high in N+1. The transfer is accepted in N+1 if hready_i = 1, and its data phase is N+2.
- Back-to-back transfers from one master, with no competitor: one transfer per cycle, no idle bubble.
- Round-robin with both masters requesting continuously: ownership alternates every accepted beat.
- Simultaneous v_lock_i rise and s_req_i: VECTOR wins.
- Reset asserted mid-transfer: all owners return to NONE asynchronously and all bus outputs go idle. A slave in a data phase is abandoned; this is the system-level reset contract.
- All outputs are combinational from owner registers plus inputs. There is no combinational path from hready_i into the owner registers' own outputs.

## Structure
- Shared package `rvv_bus_pkg`:
  - `hsize_t` (BYTE / HALFWORD / WORD).
  - `bus_owner_e` {NONE, SCALAR, VECTOR}.
  - HTRANS constants IDLE / NONSEQ.
  - HRESP constants OKAY / ERROR.
- The next-owner selection is one sub-module, `rvv_arb_pick`: combinational, inputs reqs/lock/last_owner/RR_EN, output next owner. The rest stays in `rvv_ahb_arbiter`.

## Test plan
- Reset, then s_req_i = 1, haddr = 0x100, hready_i = 1 -> s_gnt_o = 1 next cycle, haddr_o = 0x100, htrans_o = 2'b10. Data phase one cycle later carries s_hwdata_i.
- Both masters request continuously, RR_EN = 1 -> haddr_o alternates scalar/vector addresses each cycle. hwdata_o lags addr by one cycle with the matching owner.
- Scalar owns, v_lock_i rises, hready_i held 0 for 3 cycles -> owner stays SCALAR for those 3 cycles. VECTOR gains the grant on the first hready_i = 1 edge, and the scalar data phase completes with s_hready_o = 1.
- Vector read, slave returns hresp_i = ERROR -> v_hresp_o = 01 and s_hresp_o = 00.
- resetn_i pulsed low mid-burst -> all outputs are 0/IDLE and gnt is 0 in the same cycle, without a clock edge.
- RR_EN = 0, both masters requesting, lock low -> vector granted every arbitration cycle and scalar gnt stays 0.

Source files
------------

// File: rtl/rvv_bus_pkg.sv
// Shared AHB-Lite bus types and constants for the core's external port.
package rvv_bus_pkg;

    typedef enum logic [2:0] {
        BYTE     = 3'b000,
        HALFWORD = 3'b001,
        WORD     = 3'b010
    } hsize_t;

    typedef enum logic [1:0] {
        NONE   = 2'b00,
        SCALAR = 2'b01,
        VECTOR = 2'b10
    } bus_owner_e;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] NONSEQ = 2'b10;

    localparam logic [1:0] OKAY  = 2'b00;
    localparam logic [1:0] ERROR = 2'b01;

endpackage

// File: rtl/rvv_arb_pick.sv
// Next address-phase owner selection: lock, then round-robin or fixed priority.
module rvv_arb_pick
    import rvv_bus_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic       s_req_i,
    input  logic       v_req_i,
    input  logic       lock_i,
    input  bus_owner_e last_owner_i,
    output bus_owner_e next_owner_o
);

    // Lock overrides everything; with both pending, RR favours whoever was not served last.
    always_comb begin
        next_owner_o = NONE;
        if (lock_i) begin
            next_owner_o = VECTOR;
        end else if (s_req_i && v_req_i) begin
            if (RR_EN && (last_owner_i == VECTOR)) begin
                next_owner_o = SCALAR;
            end else begin
                next_owner_o = VECTOR;
            end
        end else if (s_req_i) begin
            next_owner_o = SCALAR;
        end else if (v_req_i) begin
            next_owner_o = VECTOR;
        end
    end

endmodule

// File: rtl/rvv_ahb_arbiter.sv
// Two-master AHB-Lite arbiter with separate address- and data-phase ownership.
module rvv_ahb_arbiter
    import rvv_bus_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter bit          RR_EN      = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  resetn_i,
    input  logic                  s_req_i,
    input  logic [DATA_WIDTH-1:0] s_haddr_i,
    input  logic                  s_hwrite_i,
    input  logic [2:0]            s_hsize_i,
    input  logic [DATA_WIDTH-1:0] s_hwdata_i,
    input  logic                  v_req_i,
    input  logic [DATA_WIDTH-1:0] v_haddr_i,
    input  logic                  v_hwrite_i,
    input  logic [2:0]            v_hsize_i,
    input  logic [DATA_WIDTH-1:0] v_hwdata_i,
    input  logic                  v_lock_i,
    output logic                  s_gnt_o,
    output logic                  v_gnt_o,
    output logic                  s_hready_o,
    output logic                  v_hready_o,
    output logic [1:0]            s_hresp_o,
    output logic [1:0]            v_hresp_o,
    output logic [DATA_WIDTH-1:0] hrdata_o,
    output logic [DATA_WIDTH-1:0] haddr_o,
    output logic [DATA_WIDTH-1:0] hwdata_o,
    output logic [2:0]            hsize_o,
    output logic                  hwrite_o,
    output logic [1:0]            htrans_o,
    input  logic [DATA_WIDTH-1:0] hrdata_i,
    input  logic                  hready_i,
    input  logic [1:0]            hresp_i
);

    bus_owner_e addr_owner_q;
    bus_owner_e data_owner_q;
    bus_owner_e last_owner_q;
    bus_owner_e pick_last;
    bus_owner_e next_owner;

    logic s_gnt;
    logic v_gnt;
    logic s_acc;
    logic v_acc;
    logic acc;

    assign s_gnt = (addr_owner_q == SCALAR);
    assign v_gnt = (addr_owner_q == VECTOR);
    assign s_acc = s_gnt & s_req_i & hready_i;
    assign v_acc = v_gnt & v_req_i & hready_i;
    assign acc   = s_acc | v_acc;

    // A beat accepted this cycle already counts as served when breaking the next tie.
    assign pick_last = acc ? addr_owner_q : last_owner_q;

    rvv_arb_pick #(
        .RR_EN(RR_EN)
    ) u_pick (
        .s_req_i     (s_req_i),
        .v_req_i     (v_req_i),
        .lock_i      (v_lock_i),
        .last_owner_i(pick_last),
        .next_owner_o(next_owner)
    );

    // Ownership registers advance only on hready_i; a stalled slave freezes both phases.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            addr_owner_q <= NONE;
            data_owner_q <= NONE;
            last_owner_q <= NONE;
        end else if (hready_i) begin
            addr_owner_q <= next_owner;
            data_owner_q <= acc ? addr_owner_q : NONE;
            if (acc) begin
                last_owner_q <= addr_owner_q;
            end
        end
    end

    // Address-phase mux driven by the address owner.
    always_comb begin
        haddr_o  = '0;
        hwrite_o = 1'b0;
        hsize_o  = WORD;
        htrans_o = IDLE;
        case (addr_owner_q)
            SCALAR: begin
                haddr_o  = s_haddr_i;
                hwrite_o = s_hwrite_i;
                hsize_o  = s_hsize_i;
                htrans_o = s_req_i ? NONSEQ : IDLE;
            end
            VECTOR: begin
                haddr_o  = v_haddr_i;
                hwrite_o = v_hwrite_i;
                hsize_o  = v_hsize_i;
                htrans_o = v_req_i ? NONSEQ : IDLE;
            end
            default: ;
        endcase
    end

    // Data-phase mux and per-master response routing driven by the data owner.
    always_comb begin
        hwdata_o  = '0;
        s_hresp_o = OKAY;
        v_hresp_o = OKAY;
        case (data_owner_q)
            SCALAR: begin
                hwdata_o  = s_hwdata_i;
                s_hresp_o = hresp_i;
            end
            VECTOR: begin
                hwdata_o  = v_hwdata_i;
                v_hresp_o = hresp_i;
            end
            default: ;
        endcase
    end

    assign s_gnt_o    = s_gnt;
    assign v_gnt_o    = v_gnt;
    assign s_hready_o = hready_i & (s_gnt | (data_owner_q == SCALAR));
    assign v_hready_o = hready_i & (v_gnt | (data_owner_q == VECTOR));
    assign hrdata_o   = hrdata_i;

endmodule

// File: tb/tb_rvv_ahb_arbiter.sv
// Bench: two arbiters (round-robin and fixed priority) against a transaction-level model.
module tb_rvv_ahb_arbiter;

    logic        clk_i = 1'b0;
    logic        resetn_i;
    logic        s_req, v_req, s_hwrite, v_hwrite, v_lock, hready;
    logic [31:0] s_haddr, v_haddr, s_hwdata, v_hwdata, hrdata_in;
    logic [2:0]  s_hsize, v_hsize;
    logic [1:0]  hresp;

    logic        s_gnt [2];
    logic        v_gnt [2];
    logic        s_hready [2];
    logic        v_hready [2];
    logic [1:0]  s_hresp [2];
    logic [1:0]  v_hresp [2];
    logic [31:0] hrdata [2];
    logic [31:0] haddr [2];
    logic [31:0] hwdata [2];
    logic [2:0]  hsize [2];
    logic        hwrite [2];
    logic [1:0]  htrans [2];

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    // Model state per instance: 0 = nobody, 1 = scalar, 2 = vector.
    int a_own [2];
    int d_own [2];
    int served [2];

    always #5 clk_i = ~clk_i;

    rvv_ahb_arbiter #(.DATA_WIDTH(32), .RR_EN(1'b1)) u_rr (
        .clk_i(clk_i), .resetn_i(resetn_i),
        .s_req_i(s_req), .s_haddr_i(s_haddr), .s_hwrite_i(s_hwrite), .s_hsize_i(s_hsize),
        .s_hwdata_i(s_hwdata),
        .v_req_i(v_req), .v_haddr_i(v_haddr), .v_hwrite_i(v_hwrite), .v_hsize_i(v_hsize),
        .v_hwdata_i(v_hwdata), .v_lock_i(v_lock),
        .s_gnt_o(s_gnt[0]), .v_gnt_o(v_gnt[0]), .s_hready_o(s_hready[0]),
        .v_hready_o(v_hready[0]), .s_hresp_o(s_hresp[0]), .v_hresp_o(v_hresp[0]),
        .hrdata_o(hrdata[0]), .haddr_o(haddr[0]), .hwdata_o(hwdata[0]), .hsize_o(hsize[0]),
        .hwrite_o(hwrite[0]), .htrans_o(htrans[0]),
        .hrdata_i(hrdata_in), .hready_i(hready), .hresp_i(hresp)
    );

    rvv_ahb_arbiter #(.DATA_WIDTH(32), .RR_EN(1'b0)) u_fp (
        .clk_i(clk_i), .resetn_i(resetn_i),
        .s_req_i(s_req), .s_haddr_i(s_haddr), .s_hwrite_i(s_hwrite), .s_hsize_i(s_hsize),
        .s_hwdata_i(s_hwdata),
        .v_req_i(v_req), .v_haddr_i(v_haddr), .v_hwrite_i(v_hwrite), .v_hsize_i(v_hsize),
        .v_hwdata_i(v_hwdata), .v_lock_i(v_lock),
        .s_gnt_o(s_gnt[1]), .v_gnt_o(v_gnt[1]), .s_hready_o(s_hready[1]),
        .v_hready_o(v_hready[1]), .s_hresp_o(s_hresp[1]), .v_hresp_o(v_hresp[1]),
        .hrdata_o(hrdata[1]), .haddr_o(haddr[1]), .hwdata_o(hwdata[1]), .hsize_o(hsize[1]),
        .hwrite_o(hwrite[1]), .htrans_o(htrans[1]),
        .hrdata_i(hrdata_in), .hready_i(hready), .hresp_i(hresp)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Who gets the bus next, straight from the arbitration rules.
    function automatic int model_pick(int k, bit sr, bit vr, bit lk, int last);
        if (lk) return 2;
        if (sr && vr) begin
            if (k == 1) return 2;
            return (last == 2) ? 1 : 2;
        end
        if (sr) return 1;
        if (vr) return 2;
        return 0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            a_own[k]  = 0;
            d_own[k]  = 0;
            served[k] = 0;
        end
    endtask

    // Clock-edge behaviour of the model, called right at the rising edge.
    task automatic model_update();
        if (!resetn_i) begin
            model_reset();
        end else if (hready) begin
            for (int k = 0; k < 2; k++) begin
                bit took;
                took = (a_own[k] == 1 && s_req) || (a_own[k] == 2 && v_req);
                if (took) served[k] = a_own[k];
                d_own[k] = took ? a_own[k] : 0;
                a_own[k] = model_pick(k, s_req, v_req, v_lock, served[k]);
            end
        end
    endtask

    task automatic check_all();
        int a, d;
        logic [31:0] e_addr, e_wdata;
        logic [2:0]  e_size;
        logic        e_write, e_req;
        for (int k = 0; k < 2; k++) begin
            a = a_own[k];
            d = d_own[k];
            e_addr  = (a == 1) ? s_haddr  : (a == 2) ? v_haddr  : 32'h0;
            e_write = (a == 1) ? s_hwrite : (a == 2) ? v_hwrite : 1'b0;
            e_size  = (a == 1) ? s_hsize  : (a == 2) ? v_hsize  : 3'b010;
            e_req   = (a == 1) ? s_req    : (a == 2) ? v_req    : 1'b0;
            e_wdata = (d == 1) ? s_hwdata : (d == 2) ? v_hwdata : 32'h0;
            chk($sformatf("s_gnt%0d", k), 32'(s_gnt[k]), 32'(a == 1));
            chk($sformatf("v_gnt%0d", k), 32'(v_gnt[k]), 32'(a == 2));
            chk($sformatf("haddr%0d", k), haddr[k], e_addr);
            chk($sformatf("hwrite%0d", k), 32'(hwrite[k]), 32'(e_write));
            chk($sformatf("hsize%0d", k), 32'(hsize[k]), 32'(e_size));
            chk($sformatf("htrans%0d", k), 32'(htrans[k]), e_req ? 32'd2 : 32'd0);
            chk($sformatf("hwdata%0d", k), hwdata[k], e_wdata);
            chk($sformatf("s_hready%0d", k), 32'(s_hready[k]),
                32'(hready && (a == 1 || d == 1)));
            chk($sformatf("v_hready%0d", k), 32'(v_hready[k]),
                32'(hready && (a == 2 || d == 2)));
            chk($sformatf("s_hresp%0d", k), 32'(s_hresp[k]), (d == 1) ? 32'(hresp) : 32'd0);
            chk($sformatf("v_hresp%0d", k), 32'(v_hresp[k]), (d == 2) ? 32'(hresp) : 32'd0);
            chk($sformatf("hrdata%0d", k), hrdata[k], hrdata_in);
        end
    endtask

    task automatic sample();
        @(negedge clk_i);
        check_all();
    endtask

    task automatic tick();
        @(posedge clk_i);
        model_update();
        #1;
    endtask

    initial begin
        logic [31:0] prev;
        resetn_i = 1'b0;
        s_req = 0; v_req = 0; s_hwrite = 0; v_hwrite = 0; v_lock = 0; hready = 1;
        s_haddr = 0; v_haddr = 0; s_hwdata = 0; v_hwdata = 0; hrdata_in = 32'hDEAD_BEEF;
        s_hsize = 3'b010; v_hsize = 3'b010; hresp = 2'b00;
        model_reset();

        // Reset state
        sample();
        chk("rst_htrans", 32'(htrans[0]), 32'd0);
        tick();
        resetn_i = 1'b1;

        // Single scalar write: grant N+1, data phase N+2
        s_req = 1; s_haddr = 32'h100; s_hwrite = 1; s_hwdata = 32'hA5A5_0001;
        sample();
        chk("t1_gnt_n", 32'(s_gnt[0]), 32'd0);
        tick();
        sample();
        chk("t1_gnt_n1", 32'(s_gnt[0]), 32'd1);
        chk("t1_haddr", haddr[0], 32'h100);
        chk("t1_htrans", 32'(htrans[0]), 32'd2);
        tick();
        s_req = 0;
        sample();
        chk("t1_hwdata", hwdata[0], 32'hA5A5_0001);
        chk("t1_s_hready", 32'(s_hready[0]), 32'd1);
        tick();
        sample();
        tick();

        // Both masters continuously: RR alternates, fixed priority keeps vector
        s_req = 1; v_req = 1; s_haddr = 32'h200; v_haddr = 32'h300;
        s_hwdata = 32'h1111; v_hwdata = 32'h2222;
        prev = 32'h0;
        for (int i = 0; i < 8; i++) begin
            sample();
            if (i >= 2) begin
                chk("t2_alt", haddr[0], (prev == 32'h200) ? 32'h300 : 32'h200);
                chk("t2_wdata", hwdata[0], (prev == 32'h200) ? 32'h1111 : 32'h2222);
            end
            if (i >= 1) begin
                chk("t6_vgnt", 32'(v_gnt[1]), 32'd1);
                chk("t6_sgnt", 32'(s_gnt[1]), 32'd0);
            end
            prev = haddr[0];
            tick();
        end

        // Drain to idle, then scalar transfer stalled while lock rises
        s_req = 0; v_req = 0;
        repeat (3) begin sample(); tick(); end
        s_req = 1; s_haddr = 32'h400; s_hwdata = 32'h4444;
        sample(); tick();
        sample(); tick();
        s_req = 0; hready = 0; v_lock = 1; v_req = 1; v_haddr = 32'h500; v_hwrite = 0;
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("t3_hold_s", 32'(s_gnt[0]), 32'd1);
            chk("t3_stall", 32'(s_hready[0]), 32'd0);
            tick();
        end
        hready = 1;
        sample();
        chk("t3_s_done", 32'(s_hready[0]), 32'd1);
        chk("t3_wdata", hwdata[0], 32'h4444);
        tick();
        sample();
        chk("t3_v_gnt", 32'(v_gnt[0]), 32'd1);
        chk("t3_s_nogn", 32'(s_gnt[0]), 32'd0);

        // Vector read answered with ERROR
        v_lock = 0;
        tick();
        v_req = 0; hresp = 2'b01; hrdata_in = 32'h0BAD_F00D;
        sample();
        chk("t4_v_hresp", 32'(v_hresp[0]), 32'd1);
        chk("t4_s_hresp", 32'(s_hresp[0]), 32'd0);
        tick();
        hresp = 2'b00;

        // Asynchronous reset in the middle of a burst
        s_req = 1; v_req = 1;
        sample(); tick();
        sample(); tick();
        sample();
        #2 resetn_i = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            chk("t5_sgnt", 32'(s_gnt[k]), 32'd0);
            chk("t5_vgnt", 32'(v_gnt[k]), 32'd0);
            chk("t5_htrans", 32'(htrans[k]), 32'd0);
            chk("t5_haddr", haddr[k], 32'd0);
            chk("t5_hwdata", hwdata[k], 32'd0);
        end
        check_all();
        tick();
        resetn_i = 1'b1;

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            s_req     = ($urandom_range(0, 9) < 7);
            v_req     = ($urandom_range(0, 9) < 6);
            v_lock    = ($urandom_range(0, 9) == 0);
            hready    = ($urandom_range(0, 3) != 0);
            s_haddr   = $urandom;
            v_haddr   = $urandom;
            s_hwdata  = $urandom;
            v_hwdata  = $urandom;
            s_hwrite  = 1'($urandom_range(0, 1));
            v_hwrite  = 1'($urandom_range(0, 1));
            s_hsize   = 3'($urandom_range(0, 2));
            v_hsize   = 3'($urandom_range(0, 2));
            hresp     = 2'($urandom_range(0, 1));
            hrdata_in = $urandom;
            sample();
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
